vector_mem_sequencer: RTL

VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

---
 rtl/vector_mem_sequencer_if.sv | 32 +++
 rtl/vector_mem_sequencer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/vector_mem_sequencer_if.sv
// Request/response bundle between the execute stage, the vector memory
// sequencer and a single-ported word-wide data memory.
interface vector_mem_sequencer_if #(
  parameter int V = 128,
  parameter int N = 32
);
  logic         req_valid;
  logic         req_wen;
  logic         req_vec;
  logic [V-1:0] addr_vector;
  logic [V-1:0] data_vector;
  logic [N-1:0] mem_rdata;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_we;
  logic         mem_re;
  logic         stall_cpu;
  logic         done;
  logic [V-1:0] load_vector;

  // Sequencer view: takes requests and read data, drives the memory port.
  modport slave (
    input  req_valid, req_wen, req_vec, addr_vector, data_vector, mem_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re, stall_cpu, done, load_vector
  );

  // Environment view: execute stage plus data memory.
  modport master (
    output req_valid, req_wen, req_vec, addr_vector, data_vector, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re, stall_cpu, done, load_vector
  );
endinterface

// File: rtl/vector_mem_sequencer.sv
// Serialises a scalar or L-lane vector load/store onto a word-wide memory
// port, one lane per cycle, and assembles load results into load_vector.
module vector_mem_sequencer #(
  parameter int V = 128,
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  vector_mem_sequencer_if.slave bus
);
  localparam int L  = V / N;
  localparam int LW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lane_q;
  logic [LW-1:0] pend_lane_q;
  logic          pend_q;
  logic          wen_q;
  logic          vec_q;
  logic [V-1:0]  addr_q;
  logic [V-1:0]  data_q;
  logic [V-1:0]  load_q;
  logic          last_lane;

  logic [N-1:0]  mem_addr_c;
  logic [N-1:0]  mem_wdata_c;
  logic          mem_we_c;
  logic          mem_re_c;
  logic          stall_c;
  logic          done_c;

  assign last_lane = (lane_q == (vec_q ? LW'(L - 1) : '0));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch of the case can infer a latch.
    state_d     = state_q;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    stall_c     = 1'b0;
    done_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = ISSUE;
          // Reset must hold every output low even with a request present.
          stall_c = rst;
        end
      end
      ISSUE: begin
        stall_c     = 1'b1;
        mem_addr_c  = addr_q[int'(lane_q) * N +: N];
        mem_we_c    = wen_q;
        mem_re_c    = !wen_q;
        mem_wdata_c = wen_q ? data_q[int'(lane_q) * N +: N] : '0;
        if (last_lane) state_d = wen_q ? DONE : WAIT;
      end
      WAIT: begin
        stall_c = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      pend_lane_q <= '0;
      pend_q      <= 1'b0;
      wen_q       <= 1'b0;
      vec_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      load_q      <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            wen_q  <= bus.req_wen;
            vec_q  <= bus.req_vec;
            addr_q <= bus.addr_vector;
            data_q <= bus.data_vector;
            lane_q <= '0;
            if (!bus.req_wen) load_q <= '0;
          end
        end
        ISSUE: begin
          lane_q <= lane_q + LW'(1);
          if (!wen_q) begin
            pend_q      <= 1'b1;
            pend_lane_q <= lane_q;
          end
        end
        default: ;
      endcase
      // Read data returns one cycle after its strobe; the last word lands during WAIT.
      if (pend_q) load_q[int'(pend_lane_q) * N +: N] <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_wdata   = mem_wdata_c;
  assign bus.mem_we      = mem_we_c;
  assign bus.mem_re      = mem_re_c;
  assign bus.stall_cpu   = stall_c;
  assign bus.done        = done_c;
  assign bus.load_vector = load_q;
endmodule
